cpu_mem_responder: RTL and testbench

Memory-side responder for the single-cycle RISC-V core's split instruction/data bus. It serves instruction fetches and data loads with zero-wait combinational read data, and commits stores on the clock edge. It also decodes a small MMIO window: a TOHOST halt/exit register, a cycle counter and a store counter. It sits between the core and the testbench, and records sticky error flags for misaligned and out-of-range accesses.

---
 rtl/cpu_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle RISC-V core: zero-wait instruction/data reads
// from a word RAM, clocked stores, and a 16-byte MMIO window (TOHOST, counters, error flags).
module cpu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        err_misalign,
    output logic        err_range,
    output logic [31:0] err_addr
);
    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        CLS_RAM,
        CLS_MMIO,
        CLS_RANGE,
        CLS_MISALIGN
    } addr_cls_e;

    // Misalignment takes precedence over every other class.
    function automatic addr_cls_e classify(input logic [31:0] a);
        if (a[1:0] != 2'b00) begin
            return CLS_MISALIGN;
        end else if (a[31:4] == MMIO_BASE[31:4]) begin
            return CLS_MMIO;
        end else if (a[31:AW+2] == '0) begin
            return CLS_RAM;
        end else begin
            return CLS_RANGE;
        end
    endfunction

    addr_cls_e     instr_cls;
    addr_cls_e     data_cls;
    logic [AW-1:0] instr_idx;
    logic [AW-1:0] data_idx;
    logic          store_en;
    logic          ram_we;
    logic          tohost_we;
    logic          data_chk;
    logic          fetch_chk;
    logic          d_mis;
    logic          d_rng;
    logic          f_mis;
    logic          f_rng;

    logic          halt_q,      halt_d;
    logic [31:0]   exit_code_q, exit_code_d;
    logic [31:0]   cycle_cnt_q, cycle_cnt_d;
    logic [31:0]   store_cnt_q, store_cnt_d;
    logic          err_mis_q,   err_mis_d;
    logic          err_rng_q,   err_rng_d;
    logic [31:0]   err_addr_q,  err_addr_d;

    logic [31:0]   mem [DEPTH_WORDS];

    always_comb begin
        instr_cls = classify(instr_addr);
        data_cls  = classify(data_addr);
        instr_idx = instr_addr[AW+1:2];
        data_idx  = data_addr[AW+1:2];
        store_en  = data_write && !halt_q;
        ram_we    = store_en && (data_cls == CLS_RAM);
        tohost_we = store_en && (data_cls == CLS_MMIO) && (data_addr[3:2] == 2'd0);
        // Halted stores are dropped entirely; loads keep flagging errors.
        data_chk  = data_read || store_en;
        fetch_chk = instr_read && !halt_q;
        d_mis     = data_chk && (data_cls == CLS_MISALIGN);
        d_rng     = data_chk && (data_cls == CLS_RANGE);
        f_mis     = fetch_chk && (instr_cls == CLS_MISALIGN);
        f_rng     = fetch_chk && (instr_cls == CLS_RANGE);
    end

    always_comb begin
        instr_out = NOP;
        if (fetch_chk && (instr_cls == CLS_RAM)) begin
            instr_out = mem[instr_idx];
        end
    end

    always_comb begin
        data_out = '0;
        if (data_read) begin
            case (data_cls)
                CLS_RAM: data_out = mem[data_idx];
                CLS_MMIO: begin
                    case (data_addr[3:2])
                        2'd0:    data_out = exit_code_q;
                        2'd1:    data_out = cycle_cnt_q;
                        2'd2:    data_out = store_cnt_q;
                        default: data_out = {30'b0, err_rng_q, err_mis_q};
                    endcase
                end
                default: data_out = '0;
            endcase
        end
    end

    always_comb begin
        halt_d      = halt_q || tohost_we;
        exit_code_d = tohost_we ? data_in : exit_code_q;
        cycle_cnt_d = halt_q ? cycle_cnt_q : cycle_cnt_q + 32'd1;
        store_cnt_d = ram_we ? store_cnt_q + 32'd1 : store_cnt_q;
        err_mis_d   = err_mis_q || d_mis || f_mis;
        err_rng_d   = err_rng_q || d_rng || f_rng;
        err_addr_d  = err_addr_q;
        // Only the first error is recorded; the data side wins a same-cycle tie.
        if (!err_mis_q && !err_rng_q) begin
            if (d_mis || d_rng) begin
                err_addr_d = data_addr;
            end else if (f_mis || f_rng) begin
                err_addr_d = instr_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q      <= 1'b0;
            exit_code_q <= '0;
            cycle_cnt_q <= '0;
            store_cnt_q <= '0;
            err_mis_q   <= 1'b0;
            err_rng_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
            cycle_cnt_q <= cycle_cnt_d;
            store_cnt_q <= store_cnt_d;
            err_mis_q   <= err_mis_d;
            err_rng_q   <= err_rng_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // RAM is deliberately left out of reset; reset only blocks a coincident store.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            mem[data_idx] <= data_in;
        end
    end

    assign halt         = halt_q;
    assign exit_code    = exit_code_q;
    assign err_misalign = err_mis_q;
    assign err_range    = err_rng_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: constant vector table, directed corner
// sequences, and randomized traffic compared against an address-rule reference model.
module tb_cpu_mem_responder;
    localparam int unsigned DEPTH = 16384;
    localparam logic [31:0] MB    = 32'hFFFF_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NV    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        halt;
    logic [31:0] exit_code;
    logic        err_misalign;
    logic        err_range;
    logic [31:0] err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_addr(instr_addr), .instr_out(instr_out),
        .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
        .data_in(data_in), .data_out(data_out),
        .halt(halt), .exit_code(exit_code),
        .err_misalign(err_misalign), .err_range(err_range), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [int];
    logic        m_halt, m_emis, m_erng;
    logic [31:0] m_exit, m_cyc, m_scnt, m_eaddr;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] di;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // 0 = RAM, 1 = MMIO, 2 = out of range, 3 = misaligned
    function automatic int kind(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 3;
        if ((a & 32'hFFFF_FFF0) == MB) return 1;
        if (64'(a) < 64'(4 * DEPTH)) return 0;
        return 2;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        return m_mem.exists(k) ? m_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        if (!instr_read || m_halt || kind(instr_addr) != 0) return NOP;
        return mem_rd(instr_addr);
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] off;
        if (!data_read) return 32'h0;
        if (kind(data_addr) == 0) return mem_rd(data_addr);
        if (kind(data_addr) != 1) return 32'h0;
        off = data_addr - MB;
        if (off == 0) return m_exit;
        if (off == 4) return m_cyc;
        if (off == 8) return m_scnt;
        return {30'b0, m_erng, m_emis};
    endfunction

    task automatic model_edge();
        int dk, ik;
        bit st, dmis, drng, fmis, frng;
        if (rst) begin
            m_halt = 0; m_exit = 0; m_cyc = 0; m_scnt = 0;
            m_emis = 0; m_erng = 0; m_eaddr = 0;
            return;
        end
        dk   = kind(data_addr);
        ik   = kind(instr_addr);
        st   = data_write && !m_halt;
        dmis = (data_read || st) && dk == 3;
        drng = (data_read || st) && dk == 2;
        fmis = instr_read && !m_halt && ik == 3;
        frng = instr_read && !m_halt && ik == 2;
        if ((dmis || drng || fmis || frng) && !m_emis && !m_erng)
            m_eaddr = (dmis || drng) ? data_addr : instr_addr;
        m_emis = m_emis | dmis | fmis;
        m_erng = m_erng | drng | frng;
        if (!m_halt) m_cyc = m_cyc + 1;
        if (st && dk == 0) begin
            m_mem[int'(data_addr >> 2)] = data_in;
            m_scnt = m_scnt + 1;
        end
        if (st && dk == 1 && data_addr == MB) begin
            m_halt = 1;
            m_exit = data_in;
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] di);
        instr_read = ir; instr_addr = ia;
        data_read = dr; data_write = dw; data_addr = da; data_in = di;
    endtask

    // Called 1 time unit after a posedge with inputs already driven.
    task automatic tick();
        #3;
        check("instr_out", instr_out, exp_instr());
        check("data_out", data_out, exp_data());
        @(posedge clk);
        model_edge();
        #1;
        check("halt", 32'(halt), 32'(m_halt));
        check("exit_code", exit_code, m_exit);
        check("err_misalign", 32'(err_misalign), 32'(m_emis));
        check("err_range", 32'(err_range), 32'(m_erng));
        check("err_addr", err_addr, m_eaddr);
    endtask

    task automatic reset_cycle(input logic dw, input logic [31:0] da, input logic [31:0] di);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, dw, da, di);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr(input bit for_store);
        int unsigned r;
        r = $urandom_range(99);
        if (r < 70) return {22'b0, 8'($urandom_range(255, for_store ? 2 : 0)), 2'b00};
        if (r < 85) return MB + 32'(4 * $urandom_range(3, 1));
        if (r < 93) return 32'h0001_0000 + 32'(4 * $urandom_range(1023));
        return {22'b0, 8'($urandom_range(255)), 2'($urandom_range(3, 1))};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0,   1'b0, 1'b1, 32'h100,   32'hDEADBEEF, 32'h00500093, 32'h0};
        vecs[1] = '{1'b1, 32'h4,   1'b1, 1'b0, 32'h100,   32'h0,        32'h0000A103, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, MB + 8,    32'h0,        NOP,          32'h1};
        vecs[3] = '{1'b1, MB,      1'b1, 1'b1, 32'h100,   32'h12345678, NOP,          32'hDEADBEEF};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100,   32'h0,        NOP,          32'h12345678};
        vecs[5] = '{1'b1, 32'h0,   1'b1, 1'b0, MB + 12,   32'h0,        32'h00500093, 32'h0};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h104,   32'hCAFEF00D, NOP,          32'h0};
        vecs[7] = '{1'b1, 32'h4,   1'b1, 1'b0, MB + 8,    32'h0,        32'h0000A103, 32'h3};
        vecs[8] = '{1'b0, 32'h0,   1'b1, 1'b0, MB,        32'h0,        NOP,          32'h0};
        vecs[9] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104,   32'h0,        NOP,          32'hCAFEF00D};

        // Power-on reset and reset values
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        check("rst_halt", 32'(halt), 32'h0);
        check("rst_exit_code", exit_code, 32'h0);
        check("rst_flags", {30'b0, err_range, err_misalign}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 4, 32'h0);
        #1 check("rst_cycle_cnt", data_out, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 8, 32'h0);
        #1 check("rst_store_cnt", data_out, 32'h0);
        rst = 1'b0;

        // Preload words 0..255 through the store port, then reset (RAM survives)
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4),
                  i == 0 ? 32'h00500093 : (i == 1 ? 32'h0000A103 : $urandom));
            tick();
        end
        reset_cycle(1'b0, 32'h0, 32'h0);

        // Constant vector table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].di);
            #3;
            check($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_i);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_d);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Randomized traffic against the model (no TOHOST writes here)
        for (int i = 0; i < 400; i++) begin
            logic wr;
            wr = ($urandom_range(9) < 4);
            drive(1'($urandom_range(1)), rand_addr(1'b0), 1'($urandom_range(1)), wr,
                  rand_addr(1'b1), $urandom);
            tick();
        end

        // RAM boundary words
        reset_cycle(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_FFFC, 32'hA5A5A5A5);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0);
        #2 check("last_word_load", data_out, 32'hA5A5A5A5);
        tick();
        check("last_word_no_err", {30'b0, err_range, err_misalign}, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
        tick();
        check("first_oor_range", 32'(err_range), 32'h1);
        check("first_oor_addr", err_addr, 32'h0001_0000);

        // Misaligned store, then out-of-range store keeps the first err_addr
        reset_cycle(1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h102, 32'h11111111);
        tick();
        check("mis_flag", 32'(err_misalign), 32'h1);
        check("mis_range_clear", 32'(err_range), 32'h0);
        check("mis_addr", err_addr, 32'h102);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0004_0000, 32'h22222222);
        tick();
        check("oor_flag", 32'(err_range), 32'h1);
        check("oor_addr_kept", err_addr, 32'h102);
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 12, 32'h0);
        #2 check("mmio_flags", data_out, 32'h3);
        tick();

        // Fetch and data errors in the same cycle: data address wins
        reset_cycle(1'b0, 32'h0, 32'h0);
        drive(1'b1, 32'h6, 1'b1, 1'b0, 32'h0002_0000, 32'h0);
        tick();
        check("tie_flags", {30'b0, err_range, err_misalign}, 32'h3);
        check("tie_addr", err_addr, 32'h0002_0000);

        // Cycle counter after 10 reset-free cycles
        reset_cycle(1'b0, 32'h0, 32'h0);
        repeat (10) tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 4, 32'h0);
        #2 check("cycle_cnt_10", data_out, 32'd10);
        tick();

        // Halt via TOHOST
        drive(1'b0, 32'h0, 1'b0, 1'b1, MB, 32'h0000002A);
        tick();
        check("halt_set", 32'(halt), 32'h1);
        check("exit_42", exit_code, 32'd42);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2 check("halted_fetch_nop", instr_out, NOP);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h0BADF00D);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 4, 32'h0);
        tick();
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB, 32'h0);
        #2 check("halted_tohost_load", data_out, 32'd42);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h3, 32'h0);
        tick();
        check("halted_load_err", 32'(err_misalign), 32'h1);

        // Reset with a coincident store: reset wins and fetch resumes
        reset_cycle(1'b1, 32'h200, 32'hFFFFFFFF);
        check("post_rst_halt", 32'(halt), 32'h0);
        check("post_rst_flags", {30'b0, err_range, err_misalign}, 32'h0);
        drive(1'b1, 32'h0, 1'b1, 1'b0, MB + 4, 32'h0);
        #2 check("post_rst_cycle", data_out, 32'h0);
        check("post_rst_fetch", instr_out, 32'h00500093);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, MB + 8, 32'h0);
        #2 check("post_rst_store_cnt", data_out, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
